// File: rtl/hazard_detection_unit.sv
// Stall/flush controller beside ID: load-use stalls, busywait freezes, taken-branch flushes.
// Controls are combinational from state and inputs; optional stats counters under HDU_STATS_EN.
module hazard_detection_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_WAIT     = 63
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [REG_ADDR_W-1:0] ID_RS1,
   input  logic [REG_ADDR_W-1:0] ID_RS2,
   input  logic                  ID_USES_RS1,
   input  logic                  ID_USES_RS2,
   input  logic [REG_ADDR_W-1:0] EX_RD,
   input  logic                  EX_MEM_READ,
   input  logic                  BRANCH_TAKEN,
   input  logic                  MEM_BUSYWAIT,
   output logic                  PC_HOLD,
   output logic                  IFID_HOLD,
   output logic                  IDEX_HOLD,
   output logic                  EXMEM_HOLD,
   output logic                  IDEX_BUBBLE,
   output logic                  IFID_FLUSH,
   output logic                  MEM_TIMEOUT,
   output logic [15:0]           LOAD_STALLS,
   output logic [15:0]           FLUSH_COUNT
);

   typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} state_t;

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);
   localparam logic [2:0] LP_RELOAD   = 3'(FLUSH_CYCLES - 1);

   state_t     r_state, r_saved_state;
   logic [7:0] r_wait_cnt;
   logic [2:0] r_flush_cnt;
   logic       r_timeout;

   state_t     w_eff_state, w_nxt_state, w_nxt_saved;
   logic [7:0] w_nxt_wait;
   logic [2:0] w_nxt_flush;
   logic       w_set_timeout;
   logic       w_load_use;
   logic       w_pc_hold, w_ifid_hold, w_idex_hold, w_exmem_hold, w_idex_bubble, w_ifid_flush;

   assign w_load_use = EX_MEM_READ && (EX_RD != '0) &&
                       ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));

   // Once a freeze ends, behave as the state that was interrupted, in the same cycle.
   assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_saved_state : r_state;

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_saved   = r_saved_state;
      w_nxt_wait    = r_wait_cnt;
      w_nxt_flush   = r_flush_cnt;
      w_set_timeout = 1'b0;
      w_pc_hold     = 1'b0;
      w_ifid_hold   = 1'b0;
      w_idex_hold   = 1'b0;
      w_exmem_hold  = 1'b0;
      w_idex_bubble = 1'b0;
      w_ifid_flush  = 1'b0;
      if (MEM_BUSYWAIT) begin
         w_pc_hold     = 1'b1;
         w_ifid_hold   = 1'b1;
         w_idex_hold   = 1'b1;
         w_exmem_hold  = 1'b1;
         w_nxt_state   = ST_MEM_WAIT;
         w_nxt_saved   = w_eff_state;
         w_nxt_wait    = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
         w_set_timeout = (w_nxt_wait >= LP_MAX_WAIT);
      end else begin
         w_nxt_wait  = '0;
         w_nxt_state = w_eff_state;
         if (w_eff_state == ST_FLUSH) begin
            w_ifid_flush = 1'b1;
            if (BRANCH_TAKEN) begin
               w_idex_bubble = 1'b1;
               w_nxt_flush   = LP_RELOAD;
            end else begin
               w_nxt_flush = r_flush_cnt - 3'd1;
               if (r_flush_cnt <= 3'd1) w_nxt_state = ST_RUN;
            end
         end else if (BRANCH_TAKEN) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
               w_nxt_flush = LP_RELOAD;
               w_nxt_state = ST_FLUSH;
            end
         end else if (w_load_use) begin
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= ST_RUN;
         r_saved_state <= ST_RUN;
         r_wait_cnt    <= '0;
         r_flush_cnt   <= '0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_saved_state <= w_nxt_saved;
         r_wait_cnt    <= w_nxt_wait;
         r_flush_cnt   <= w_nxt_flush;
         if (w_set_timeout) r_timeout <= 1'b1;
      end
   end

   assign PC_HOLD     = RESET & w_pc_hold;
   assign IFID_HOLD   = RESET & w_ifid_hold;
   assign IDEX_HOLD   = RESET & w_idex_hold;
   assign EXMEM_HOLD  = RESET & w_exmem_hold;
   assign IDEX_BUBBLE = RESET & w_idex_bubble;
   assign IFID_FLUSH  = RESET & w_ifid_flush;
   assign MEM_TIMEOUT = r_timeout;

`ifdef HDU_STATS_EN
   logic [15:0] r_load_stalls, r_flush_count;
   logic        w_stall_evt, w_branch_evt;

   // A load-use stall is the only case raising PC_HOLD together with a bubble.
   assign w_stall_evt  = w_pc_hold && w_idex_bubble;
   assign w_branch_evt = !MEM_BUSYWAIT && BRANCH_TAKEN;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_load_stalls <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall_evt && r_load_stalls != 16'hFFFF) r_load_stalls <= r_load_stalls + 16'd1;
         if (w_branch_evt && r_flush_count != 16'hFFFF) r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign LOAD_STALLS = r_load_stalls;
   assign FLUSH_COUNT = r_flush_count;
`else
   assign LOAD_STALLS = '0;
   assign FLUSH_COUNT = '0;
`endif

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall and flush controller for the 5-stage RISC-V pipeline.
- The forwarding unit resolves RAW hazards whose data already exists. This block handles the cases forwarding cannot serve:
  - load-use dependencies;
  - data-memory busywait freezes;
  - taken-branch flushes.
- Sits beside the ID stage. Drives the hold, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- REG_ADDR_W, 5, register-address width.
- FLUSH_CYCLES, 2, IF/ID flush cycles per taken branch (1..7).
- MAX_WAIT, 63, busywait cycles tolerated before MEM_TIMEOUT (1..255).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ID_RS1  in  REG_ADDR_W  rs1 of instruction in ID.
- ID_RS2  in  REG_ADDR_W  rs2 of instruction in ID.
- ID_USES_RS1  in  1  ID instruction reads rs1.
- ID_USES_RS2  in  1  ID instruction reads rs2.
- EX_RD  in  REG_ADDR_W  destination of instruction in EX.
- EX_MEM_READ  in  1  EX instruction is a load.
- BRANCH_TAKEN  in  1  EX resolved a taken branch/jump.
- MEM_BUSYWAIT  in  1  data memory not ready.
- PC_HOLD  out  1  PC keeps its value.
- IFID_HOLD  out  1  IF/ID keeps its value.
- IDEX_HOLD  out  1  ID/EX keeps its value.
- EXMEM_HOLD  out  1  EX/MEM keeps its value.
- IDEX_BUBBLE  out  1  ID/EX loads a NOP.
- IFID_FLUSH  out  1  IF/ID loads a NOP.
- MEM_TIMEOUT  out  1  sticky busywait-overrun flag.
- LOAD_STALLS  out  16  load-use stall count.
- FLUSH_COUNT  out  16  taken-branch count.

Behaviour:
- Outputs are combinational from state register and inputs (zero-latency detection). State, counters and MEM_TIMEOUT are registered.
- RESET low (async):
  - state=RUN; wait counter, flush counter, stats counters = 0; MEM_TIMEOUT=0.
  - All hold/bubble/flush outputs = 0 while RESET is low.
  - Reset mid-stall or mid-flush abandons the operation immediately.
- load_use = EX_MEM_READ & EX_RD!=0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)). Register x0 never causes a hazard.
- Priority: MEM_BUSYWAIT > BRANCH_TAKEN > load_use.
- States RUN, MEM_WAIT, FLUSH:
  - Any state with MEM_BUSYWAIT=1:
    - PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD = 1; bubble/flush = 0.
    - Next state MEM_WAIT; the state held before the wait is remembered.
    - Wait counter increments, saturating at 255.
    - Counter reaching MAX_WAIT sets MEM_TIMEOUT (sticky until reset). The freeze continues regardless.
  - MEM_WAIT with MEM_BUSYWAIT=0: wait counter cleared; act exactly as the remembered state this same cycle. BRANCH_TAKEN or load_use held during the freeze is acted on now.
  - RUN, BRANCH_TAKEN=1:
    - IFID_FLUSH=1, IDEX_BUBBLE=1; load_use ignored.
    - If FLUSH_CYCLES>1: flush counter = FLUSH_CYCLES-1, next state FLUSH.
  - RUN, load_use=1: PC_HOLD=1, IFID_HOLD=1, IDEX_BUBBLE=1 for exactly one cycle; state stays RUN.
  - RUN, otherwise: all controls 0.
  - FLUSH:
    - IFID_FLUSH=1 and the flush counter decrements.
    - Return to RUN when the counter reaches 0.
    - A new BRANCH_TAKEN here reloads the counter to FLUSH_CYCLES-1 and also asserts IDEX_BUBBLE.
    - load_use is ignored.
- A FLUSH interrupted by busywait resumes with its count unchanged.

Optional Feature:
- Macro HDU_STATS_EN.
- Defined:
  - LOAD_STALLS increments on each load-use stall cycle.
  - FLUSH_COUNT increments on each accepted BRANCH_TAKEN.
  - Neither counts while MEM_BUSYWAIT=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both ports are present and driven constant 0; no counter registers exist.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 for one cycle -> PC_HOLD=IFID_HOLD=IDEX_BUBBLE=1 that cycle only; LOAD_STALLS=1.
- x0 immunity: EX_MEM_READ=1, EX_RD=0, ID_RS1=0, ID_USES_RS1=1 -> all controls 0.
- Unused operand: EX_RD=7, ID_RS1=7, ID_USES_RS1=0 -> no stall.
- Branch, FLUSH_CYCLES=2: BRANCH_TAKEN=1 with a concurrent load_use -> cycle0 IFID_FLUSH=IDEX_BUBBLE=1, no PC_HOLD; cycle1 IFID_FLUSH=1 only; cycle2 all 0; FLUSH_COUNT=1.
- Busywait during FLUSH: BRANCH_TAKEN, then MEM_BUSYWAIT=1 for 3 cycles -> all four holds=1 for 3 cycles; then one remaining IFID_FLUSH cycle; back to RUN.
- Timeout with MAX_WAIT=4: MEM_BUSYWAIT=1 for 6 cycles -> MEM_TIMEOUT rises after the 4th cycle and stays 1 after busywait drops; RESET low clears it asynchronously and all outputs read 0.
